// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// MIPS_CTRL_ADDI_EN enables ADDI decode (ADDI_EXEC/ADDI_WB states).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADDR   = 4'd3,
    S_MEMREAD   = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWRITE  = 4'd6,
    S_EXECUTE   = 4'd7,
    S_RTYPE_WB  = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MIPS_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] op_alu;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       reg_write;
  } ctrl_t;

  // FETCH as the target marks an unsupported opcode.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return S_EXECUTE;
      OP_LW, OP_SW: return S_MEMADDR;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
      OP_ADDI:      return ADDI_EN ? S_ADDI_EXEC : S_FETCH;
      default:      return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control-word decoder for the multi-cycle MIPS control.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.op_alu    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.op_alu    = ALUOP_ADD;
      end
      S_MEMADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.op_alu    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.op_alu    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.op_alu        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with bounded memory-ready wait.
// MIPS_CTRL_ADDI_EN (via mips_ctrl_pkg) adds ADDI support.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] OpALU,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           st;
  state_t           dec_next;
  logic [TMO_W-1:0] wait_cnt;
  ctrl_t            ctrl;

  assign dec_next = decode_target(opcode);

  // Counter defaults to zero so any state change (including a FETCH retry) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (st)
        S_IDLE:   st <= S_FETCH;
        S_FETCH, S_MEMREAD, S_MEMWRITE: begin
          if (mem_ready) begin
            case (st)
              S_FETCH:   st <= S_DECODE;
              S_MEMREAD: st <= S_MEMWB;
              default:   st <= S_FETCH;
            endcase
          end else if (wait_cnt == TMO_LAST) begin
            mem_err <= 1'b1;
            st      <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        S_DECODE:    st <= dec_next;
        S_MEMADDR:   st <= (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_EXECUTE:   st <= S_RTYPE_WB;
        S_ADDI_EXEC: st <= S_ADDI_WB;
        default:     st <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_decode u_decode (
    .state     (st),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign illegal_op  = (st == S_DECODE) && (dec_next == S_FETCH);
  assign state       = st;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign PCSource    = ctrl.pc_source;
  assign OpALU       = ctrl.op_alu;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl; honours MIPS_CTRL_ADDI_EN like the RTL.
module tb_mips_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, OpALU, ALUSrcB;
  logic       ALUSrcA, RegDst, RegWrite, illegal_op, mem_err;
  logic [3:0] state;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .OpALU(OpALU),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
    .RegWrite(RegWrite), .illegal_op(illegal_op), .mem_err(mem_err),
    .state(state)
  );

  always #5 clk = ~clk;

  // One expected cycle: which spec state the FSM must be in, plus the inputs/flags that qualify outputs.
  typedef struct {
    int unsigned st;
    bit          mr;
    bit          ill;
    bit          merr;
  } rec_t;

  rec_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   merr_m = 1'b0;

  // Moore table from the spec: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //  PCSource[2],OpALU[2],ALUSrcA,ALUSrcB[2],RegDst,RegWrite}
  function automatic logic [15:0] moore_word(input int unsigned st);
    case (st)
      1:       return 16'b0001000_00_00_0_01_00;
      2:       return 16'b0000000_00_00_0_11_00;
      3:       return 16'b0000000_00_00_1_10_00;
      4:       return 16'b0011000_00_00_0_00_00;
      5:       return 16'b0000010_00_00_0_00_01;
      6:       return 16'b0010100_00_00_0_00_00;
      7:       return 16'b0000000_00_10_1_00_00;
      8:       return 16'b0000000_00_00_0_00_11;
      9:       return 16'b0100000_01_01_1_00_00;
      10:      return 16'b1000000_10_00_0_00_00;
      11:      return 16'b0000000_00_00_1_10_00;
      12:      return 16'b0000000_00_00_0_00_01;
      default: return 16'b0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    bit ok;
    ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
         (op == 6'b000100) || (op == 6'b000010);
`ifdef MIPS_CTRL_ADDI_EN
    ok = ok || (op == 6'b001000);
`endif
    return ok;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rec_t        r;
    logic [21:0] a, e;
    logic        fmr;
    cyc++;
    if (q.size() > 0) begin
      r   = q.pop_front();
      fmr = (r.st == 1) && r.mr;
      a = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           PCSource, OpALU, ALUSrcA, ALUSrcB, RegDst, RegWrite,
           illegal_op, mem_err, state};
      e = {moore_word(r.st) | {fmr, 5'b0, fmr, 9'b0}, r.ill, r.merr, 4'(r.st)};
      check($sformatf("cyc%0d_st%0d", cyc, r.st), {10'b0, a}, {10'b0, e});
    end
  end

  task automatic step(input int unsigned st, input bit mr, input bit ill);
    rec_t r;
    mem_ready = mr;
    r.st = st; r.mr = mr; r.ill = ill; r.merr = merr_m;
    q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  // Memory-wait state: ready after nw low cycles, or abort after MEM_TIMEOUT low cycles.
  task automatic mwait(input int unsigned st, input int nw, output bit tmo);
    tmo = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      bit r;
      r = (i >= nw);
      step(st, r, 1'b0);
      if (r) break;
      if (i == MEM_TIMEOUT - 1) begin
        tmo    = 1'b1;
        merr_m = 1'b1;
      end
    end
  endtask

  task automatic instr(input logic [5:0] op, input int fw, input int mw);
    bit tmo;
    opcode = op;
    mwait(1, fw, tmo);
    step(2, 1'b1, !is_legal(op));
    if (is_legal(op)) begin
      case (op)
        6'b000000: begin step(7, 1'b1, 1'b0); step(8, 1'b1, 1'b0); end
        6'b100011: begin
          step(3, 1'b1, 1'b0);
          mwait(4, mw, tmo);
          if (!tmo) step(5, 1'b1, 1'b0);
        end
        6'b101011: begin step(3, 1'b1, 1'b0); mwait(6, mw, tmo); end
        6'b000100: step(9, 1'b1, 1'b0);
        6'b000010: step(10, 1'b1, 1'b0);
        6'b001000: begin step(11, 1'b1, 1'b0); step(12, 1'b1, 1'b0); end
        default: ;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step(0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(0, 1'b0, 1'b0);
    check("pin_fetch_state", {28'b0, state}, 32'd1);
    check("pin_fetch_memread", {31'b0, MemRead}, 32'd1);
    check("pin_fetch_alusrcb", {30'b0, ALUSrcB}, 32'd1);

    instr(6'b000000, 0, 0);
    instr(6'b100011, 0, 3);
    instr(6'b101011, 0, 1);
    instr(6'b000100, 0, 0);
    instr(6'b000010, 2, 0);
    instr(6'b111111, 0, 0);
    instr(6'b001000, 0, 0);

    instr(6'b100011, 0, 100);
    check("pin_tmo_mem_err", {31'b0, mem_err}, 32'd1);
    check("pin_tmo_state", {28'b0, state}, 32'd1);
    instr(6'b000000, 0, 0);
    instr(6'b000100, 1, 0);

    // Reset in the middle of a load access.
    opcode = 6'b100011;
    step(1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    step(3, 1'b1, 1'b0);
    step(4, 1'b0, 1'b0);
    rst_n  = 1'b0;
    merr_m = 1'b0;
    step(0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(0, 1'b1, 1'b0);
    check("pin_rst_mem_err", {31'b0, mem_err}, 32'd0);
    check("pin_rst_state", {28'b0, state}, 32'd1);
    instr(6'b101011, 0, 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle MIPS main control FSM that sequences the shared ALU/datapath one instruction at a time. It decodes the opcode and drives the ALU operand muxes, OpALU (consumed by the ALU control/ULA), memory, IR, PC and register-file strobes. It also waits on a memory ready handshake and bounds that wait with a timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for mem_ready in a memory state before abort (≥2)
TMO_W, 5, width of wait counter (must hold MEM_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26] from IR
mem_ready  in  1  memory completes current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  0 = PC address, 1 = ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  1 = MDR to register write data
IRWrite  out  1  latch instruction
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
OpALU  out  2  00 add, 01 sub, 10 use funct
ALUSrcA  out  1  0 = PC, 1 = reg A
ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write
illegal_op  out  1  1-cycle pulse, unsupported opcode in DECODE
mem_err  out  1  sticky, memory timeout occurred
state  out  4  current state (debug)

Behaviour:
- Async reset: state=IDLE, wait counter=0, mem_err=0. All outputs are 0 in IDLE. IDLE→FETCH unconditionally on the next edge.
- Outputs are Moore, decoded from state. The only exceptions are IRWrite, PCWrite in FETCH, and MDR-capture timing, which are qualified by mem_ready.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, OpALU=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, OpALU=00. Next state by opcode:
  - 000000 → EXECUTE
  - 100011 or 101011 → MEMADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - other → FETCH with illegal_op=1 this cycle
- MEMADDR: ALUSrcA=1, ALUSrcB=10, OpALU=00. Goes to MEMREAD if LW, else MEMWRITE. The opcode is stable from the IR.
- MEMREAD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Holds until mem_ready, then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, OpALU=10, then RTYPE_WB.
- RTYPE_WB: RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond=1, PCSource=01, then FETCH.
- JUMP: PCWrite=1, PCSource=10, then FETCH.
- Encoding: IDLE=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTE=7, RTYPE_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12. Codes 13–15 are unreachable and go to FETCH.
- Latency in cycles with a zero-wait memory:
  - R-type: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - J: 3
- Wait counter:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE, and whenever mem_ready=1.
  - Increments each cycle those states hold with mem_ready=0.
  - When it reaches MEM_TIMEOUT-1 with mem_ready still 0: set mem_err, drop the access, go to FETCH. A FETCH timeout retries fetch.
  - mem_ready=1 on the timeout cycle counts as success; no error is raised.
- mem_err clears only on reset.
- Reset mid-instruction aborts immediately; no strobe is asserted after rst_n falls.

Optional Feature:
MIPS_CTRL_ADDI_EN
- Defined: opcode 001000 in DECODE → ADDI_EXEC (ALUSrcA=1, ALUSrcB=10, OpALU=00) → ADDI_WB (RegDst=0, MemtoReg=0, RegWrite=1) → FETCH. Latency is 4 cycles.
- Undefined: 001000 is illegal (illegal_op pulse, return to FETCH), and states 11/12 are unreachable.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - OpALU constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - ALUSrcB and PCSource select constants
- One sub-module, mips_ctrl_decode: purely combinational state→control-word decoder. The FSM, wait counter and mem_err stay in the top.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release → all outputs 0 in IDLE, state=1 one cycle later, MemRead=1, ALUSrcB=01.
- R-type (opcode 000000), mem_ready=1 always → states 1,2,7,8,1. OpALU=10 in EXECUTE, RegWrite=1 and RegDst=1 in RTYPE_WB.
- LW (100011) with mem_ready low 3 cycles in MEMREAD → MEMREAD holds 4 cycles, then MEMWB with MemtoReg=1, RegWrite=1. SW (101011) → MemWrite=1, IorD=1, then FETCH with no RegWrite.
- BEQ (000100) → BRANCH with OpALU=01, PCWriteCond=1, PCSource=01. J (000010) → PCWrite=1, PCSource=10. Opcode 111111 → illegal_op=1 for exactly one cycle, next state FETCH.
- mem_ready held 0 in MEMREAD, MEM_TIMEOUT=16 → mem_err rises after 16 cycles, state returns to FETCH. mem_err stays 1 through later instructions until rst_n=0.
- Opcode 001000: with MIPS_CTRL_ADDI_EN → states 2,11,12,1 with ALUSrcB=10 then RegWrite=1, RegDst=0. Without the macro → illegal_op pulse.
